// File: rtl/mem_bus_arbiter.sv
// Round-robin memory bus arbiter with ack/grant/release sequencing and a hold-time watchdog.
// Define ARB_VGA_PRIORITY_EN to give port 0 (VGA fetch) fixed priority over the others.
module mem_bus_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int MAX_HOLD = 64,
  parameter int CNT_W    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [32*NUM_REQ-1:0]   addr_in,
  input  logic                    mem_wait,
  output logic [NUM_REQ-1:0]      ack,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      wait_out,
  output logic                    mem_req,
  output logic [31:0]             mem_addr,
  output logic                    timeout_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BUSY, S_RELEASE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] mask_q, mask_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               mem_req_q, mem_req_d;
  logic               timeout_q, timeout_d;

  logic [NUM_REQ-1:0] elig;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   winner_inc;
  logic [IDX_W:0]     cand;
  logic               found;

  assign elig = req & ~mask_q;

  // Round-robin search upward from rr_ptr, wrapping at NUM_REQ-1.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!found && elig[cand[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDX_W-1:0];
      end
    end
    if (winner == IDX_W'(NUM_REQ-1)) winner_inc = '0;
    else                             winner_inc = winner + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q & req;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_GRANT;
          owner_d = winner;
`ifdef ARB_VGA_PRIORITY_EN
          if (elig[0]) owner_d  = '0;
          else         rr_ptr_d = winner_inc;
`else
          rr_ptr_d = winner_inc;
`endif
        end
      end
      S_GRANT: begin
        cnt_d   = '0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        if (!req[owner_q]) begin
          state_d = S_RELEASE;
        end else if (cnt_q == CNT_W'(MAX_HOLD-1)) begin
          // Stuck owner: revoke, flag, and lock it out until it drops req.
          state_d         = S_RELEASE;
          timeout_d       = 1'b1;
          mask_d[owner_q] = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    ack_d     = '0;
    grant_d   = '0;
    mem_req_d = 1'b0;
    if (state_d == S_GRANT || state_d == S_BUSY) begin
      grant_d[owner_d] = 1'b1;
      mem_req_d        = 1'b1;
    end
    if (state_d == S_GRANT) ack_d[owner_d] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      mask_q    <= '0;
      timeout_q <= 1'b0;
      ack_q     <= '0;
      grant_q   <= '0;
      mem_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      timeout_q <= timeout_d;
      ack_q     <= ack_d;
      grant_q   <= grant_d;
      mem_req_q <= mem_req_d;
    end
  end

  // Address and wait follow the live owner inputs so there is no extra bus latency.
  always_comb begin
    mem_addr = '0;
    wait_out = '1;
    if (state_q == S_GRANT || state_q == S_BUSY) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (owner_q == IDX_W'(i)) mem_addr = addr_in[32*i +: 32];
      end
      wait_out[owner_q] = mem_wait;
    end
  end

  assign ack         = ack_q;
  assign grant       = grant_q;
  assign mem_req     = mem_req_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: vector table for single-owner flows plus
// hand-written contention, priority, watchdog and asynchronous-reset sequences.
module tb_mem_bus_arbiter;

  localparam logic [31:0] A0 = 32'h0000_0A00;
  localparam logic [31:0] A1 = 32'h0000_1050;
  localparam logic [31:0] A2 = 32'h0000_2CC0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [95:0] addr_in;
  logic        mem_wait = 1'b0;
  logic [2:0]  ack, grant, wait_out;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        timeout_err;

  int n_vec  = 0;
  int n_miss = 0;

  assign addr_in = {A2, A1, A0};

  mem_bus_arbiter #(.NUM_REQ(3), .MAX_HOLD(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req(req), .addr_in(addr_in), .mem_wait(mem_wait),
    .ack(ack), .grant(grant), .wait_out(wait_out), .mem_req(mem_req),
    .mem_addr(mem_addr), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  req;
    logic        mw;
    logic [2:0]  ack;
    logic [2:0]  grant;
    logic        mreq;
    logic [31:0] addr;
    logic [2:0]  wout;
    logic        to;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ack(input int budget, output int who);
    who = -1;
    for (int c = 0; c < budget && who < 0; c++) begin
      step();
      for (int i = 0; i < 3; i++) if (ack[i]) who = i;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 3'b000;
    step();
    reset = 1'b0;
  endtask

  int order[$];
  int dn[3];
  int gap, multi, who, g;
  bit seen, run;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Owner 1 flow, owner 2 wait routing, then req[1] dropped during GRANT.
    tbl[0]  = '{3'b010, 1'b0, 3'b010, 3'b010, 1'b1, A1,    3'b101, 1'b0};
    tbl[1]  = '{3'b010, 1'b0, 3'b000, 3'b010, 1'b1, A1,    3'b101, 1'b0};
    tbl[2]  = '{3'b010, 1'b1, 3'b000, 3'b010, 1'b1, A1,    3'b111, 1'b0};
    tbl[3]  = '{3'b010, 1'b0, 3'b000, 3'b010, 1'b1, A1,    3'b101, 1'b0};
    tbl[4]  = '{3'b010, 1'b0, 3'b000, 3'b010, 1'b1, A1,    3'b101, 1'b0};
    tbl[5]  = '{3'b010, 1'b0, 3'b000, 3'b010, 1'b1, A1,    3'b101, 1'b0};
    tbl[6]  = '{3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 32'h0, 3'b111, 1'b0};
    tbl[7]  = '{3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 32'h0, 3'b111, 1'b0};
    tbl[8]  = '{3'b100, 1'b1, 3'b100, 3'b100, 1'b1, A2,    3'b111, 1'b0};
    tbl[9]  = '{3'b100, 1'b1, 3'b000, 3'b100, 1'b1, A2,    3'b111, 1'b0};
    tbl[10] = '{3'b110, 1'b0, 3'b000, 3'b100, 1'b1, A2,    3'b011, 1'b0};
    tbl[11] = '{3'b010, 1'b0, 3'b000, 3'b000, 1'b0, 32'h0, 3'b111, 1'b0};
    tbl[12] = '{3'b010, 1'b0, 3'b000, 3'b000, 1'b0, 32'h0, 3'b111, 1'b0};
    tbl[13] = '{3'b010, 1'b1, 3'b010, 3'b010, 1'b1, A1,    3'b111, 1'b0};
    tbl[14] = '{3'b000, 1'b0, 3'b000, 3'b010, 1'b1, A1,    3'b101, 1'b0};
    tbl[15] = '{3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 32'h0, 3'b111, 1'b0};
    tbl[16] = '{3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 32'h0, 3'b111, 1'b0};

    #1 reset = 1'b1;
    step();
    chk("reset ack", ack, 3'b000);
    chk("reset grant", grant, 3'b000);
    chk("reset mem_req", mem_req, 1'b0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset wait_out", wait_out, 3'b111);
    chk("reset timeout_err", timeout_err, 1'b0);
    reset = 1'b0;

    for (int v = 0; v < 17; v++) begin
      req      = tbl[v].req;
      mem_wait = tbl[v].mw;
      step();
      chk($sformatf("v%0d ack", v),      ack,         tbl[v].ack);
      chk($sformatf("v%0d grant", v),    grant,       tbl[v].grant);
      chk($sformatf("v%0d mem_req", v),  mem_req,     tbl[v].mreq);
      chk($sformatf("v%0d mem_addr", v), mem_addr,    tbl[v].addr);
      chk($sformatf("v%0d wait_out", v), wait_out,    tbl[v].wout);
      chk($sformatf("v%0d timeout", v),  timeout_err, tbl[v].to);
    end

    do_reset();
`ifndef ARB_VGA_PRIORITY_EN
    // Every master requests; each drops 3 cycles after its ack then re-raises.
    req = 3'b111; gap = 0; seen = 0; multi = 0;
    for (int i = 0; i < 3; i++) dn[i] = 0;
    for (int c = 0; c < 120 && order.size() < 4; c++) begin
      step();
      for (int i = 0; i < 3; i++) if (!req[i]) req[i] = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (dn[i] > 0) begin
          dn[i]--;
          if (dn[i] == 0) req[i] = 1'b0;
        end
      end
      if ($countones(ack) > 1) multi++;
      if (ack != 3'b000) begin
        for (int i = 0; i < 3; i++) if (ack[i]) begin order.push_back(i); dn[i] = 3; end
        if (seen) chk("contention idle gap", gap, 2);
        seen = 1'b1;
        gap  = 0;
      end else if (grant == 3'b000) begin
        gap++;
      end
    end
    chk("contention grant count", order.size(), 4);
    chk("contention single ack", multi, 0);
    for (int k = 0; k < order.size() && k < 4; k++)
      chk($sformatf("contention order[%0d]", k), order[k], (k == 1) ? 1 : (k == 2) ? 2 : 0);
`else
    // Port 1 owns the bus when port 0 arrives; port 0 must beat port 2 next.
    req = 3'b110;
    wait_ack(5, who);
    chk("prio first owner", who, 1);
    step(); step();
    req = 3'b111;
    step(); step();
    chk("prio port1 keeps bus", grant, 3'b010);
    req = 3'b101;
    wait_ack(10, who);
    chk("prio port0 next", who, 0);
    req = 3'b100;
    wait_ack(10, who);
    chk("prio port2 after", who, 2);
`endif

    do_reset();
    // Watchdog with MAX_HOLD=8: GRANT plus 8 BUSY cycles before forced release.
    req = 3'b011;
    wait_ack(5, who);
    chk("wdog first owner", who, 0);
    g = 1; run = 1'b1;
    for (int c = 0; c < 20 && run; c++) begin
      step();
      if (grant == 3'b001) g++;
      else run = 1'b0;
    end
    chk("wdog grant cycles", g, 9);
    chk("wdog timeout_err set", timeout_err, 1'b1);
    wait_ack(6, who);
    chk("wdog port1 next", who, 1);
    req = 3'b001;
    wait_ack(8, who);
    chk("wdog port0 locked out", who, -1);
    req = 3'b000;
    step();
    req = 3'b001;
    wait_ack(6, who);
    chk("wdog port0 regrant", who, 0);
    chk("wdog timeout sticky", timeout_err, 1'b1);

    // Asynchronous reset between edges while port 0 is BUSY.
    mem_wait = 1'b0;
    step(); step();
    chk("busy before reset wait_out", wait_out, 3'b110);
    #2 reset = 1'b1;
    #1;
    chk("async reset mem_req", mem_req, 1'b0);
    chk("async reset grant", grant, 3'b000);
    chk("async reset wait_out", wait_out, 3'b111);
    chk("async reset mem_addr", mem_addr, 32'h0);
    chk("async reset timeout_err", timeout_err, 1'b0);
    step();
    reset = 1'b0;
    req   = 3'b111;
    wait_ack(5, who);
    chk("post reset first owner", who, 0);
    req = 3'b000;
    step(); step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
